// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller with byte/half/word/double lanes.
// Optional macro DMEM_CTRL_MISALIGN_TRAP_EN routes misaligned requests to ERR.
module dmem_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WR,
  input  logic [1:0]  SIZE,
  input  logic        UNS,
  input  logic [63:0] ADDR,
  input  logic [63:0] WDATA,
  output logic [63:0] RDATA,
  output logic        READY,
  output logic        BUSY,
  output logic        MISALIGN,
  output logic [63:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [63:0] MEM_WDATA,
  input  logic [63:0] MEM_RDATA
);

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    IDLE, RD, WR_FULL, RMW_RD, RMW_WR, DONE, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD, WR_FULL, RMW_RD, RMW_WR, DONE
  } state_t;
`endif

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [63:0] merge_q;
  logic        last;
  logic [2:0]  lo_al;
  logic        mis;
  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] ext;
  logic [63:0] lmask;
  logic [63:0] merged;

  function automatic logic [2:0] align_lo(
    input logic [1:0] s,
    input logic [2:0] a
  );
    unique case (s)
      2'b00:   return a;
      2'b01:   return {a[2:1], 1'b0};
      2'b10:   return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    unique case (s)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  assign lo_al = align_lo(SIZE, ADDR[2:0]);
  assign mis   = (lo_al != ADDR[2:0]);
  assign last  = (cnt == LAST);
  assign sh    = {addr_q[2:0], 3'b000};
  assign lane  = MEM_RDATA >> sh;
  assign lmask = size_mask(size_q);
  assign merged = (merge_q & ~(lmask << sh))
                | ((wdata_q & lmask) << sh);
  assign RDATA = rdata_q;

  // Lane extraction and sign/zero extension of the loaded value
  always_comb begin
    ext = lane;
    unique case (size_q)
      2'b00: ext = uns_q ? {56'b0, lane[7:0]}
                         : {{56{lane[7]}}, lane[7:0]};
      2'b01: ext = uns_q ? {48'b0, lane[15:0]}
                         : {{48{lane[15]}}, lane[15:0]};
      2'b10: ext = uns_q ? {32'b0, lane[31:0]}
                         : {{32{lane[31]}}, lane[31:0]};
      default: ext = lane;
    endcase
  end

  // State, wait counter, request latch and data registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state <= state_n;
      if ((state == RD || state == RMW_RD) && !last)
        cnt <= cnt + 4'd1;
      else
        cnt <= '0;
      if (state == IDLE && REQ) begin
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
        addr_q <= ADDR;
`else
        addr_q <= {ADDR[63:3], lo_al};
`endif
        wr_q    <= WR;
        size_q  <= SIZE;
        uns_q   <= UNS;
        wdata_q <= WDATA;
      end
      if (state == RD && last)
        rdata_q <= ext;
      if (state == RMW_RD && last)
        merge_q <= MEM_RDATA;
    end
  end

  // Next-state decode and Moore outputs
  always_comb begin
    state_n   = state;
    READY     = 1'b0;
    MISALIGN  = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    BUSY      = (state != IDLE);
    MEM_ADDR  = (state == IDLE) ? '0
                                : {addr_q[63:3], 3'b000};
    unique case (state)
      IDLE: begin
        if (REQ) begin
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
          if (mis)
            state_n = ERR;
          else
`endif
          if (!WR)
            state_n = RD;
          else if (SIZE == 2'b11)
            state_n = WR_FULL;
          else
            state_n = RMW_RD;
        end
      end
      RD: if (last) state_n = DONE;
      RMW_RD: if (last) state_n = RMW_WR;
      WR_FULL: begin
        MEM_WE    = 1'b1;
        MEM_WDATA = wdata_q;
        state_n   = DONE;
      end
      RMW_WR: begin
        MEM_WE    = 1'b1;
        MEM_WDATA = merged;
        state_n   = DONE;
      end
      DONE: begin
        READY   = 1'b1;
        state_n = IDLE;
      end
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
      ERR: begin
        READY    = 1'b1;
        MISALIGN = 1'b1;
        state_n  = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  logic unused;
  assign unused = ^{wr_q, mis};

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors, scoreboard queues, negedge monitor.
// Honours DMEM_CTRL_MISALIGN_TRAP_EN for misaligned-load expectations.
module tb_dmem_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ;
  logic        WR;
  logic [1:0]  SIZE;
  logic        UNS;
  logic [63:0] ADDR;
  logic [63:0] WDATA;
  logic [63:0] RDATA;
  logic        READY;
  logic        BUSY;
  logic        MISALIGN;
  logic [63:0] MEM_ADDR;
  logic        MEM_WE;
  logic [63:0] MEM_WDATA;
  logic [63:0] MEM_RDATA;

  dmem_ctrl #(.WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WR(WR),
    .SIZE(SIZE), .UNS(UNS), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .READY(READY), .BUSY(BUSY),
    .MISALIGN(MISALIGN), .MEM_ADDR(MEM_ADDR),
    .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] rd;
    logic        mis;
    int          lat;
    int          icyc;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } wexp_t;

  exp_t  exp_q[$];
  wexp_t wr_q[$];

  int applied = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int nissued = 0;
  logic chk_idle = 1'b0;
  logic fin_chk = 1'b0;
  logic load_mem = 1'b1;
  logic [63:0] mem [0:15];

  assign MEM_RDATA = mem[MEM_ADDR[6:3]];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[1] <= 64'h0000_0000_0000_00F0;
      mem[2] <= 64'h8877_6655_4433_2211;
    end else if (MEM_WE) begin
      mem[MEM_ADDR[6:3]] <= MEM_WDATA;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] ex);
    applied++;
    if (act !== ex) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, ex);
    end
  endtask

  // Monitor: scoreboard pops and one-shot checks
  always @(negedge CLK) begin
    if (!RESET) begin
      if (READY) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", RDATA, e.rd);
          chk("misalign", {63'b0, MISALIGN}, {63'b0, e.mis});
          chk("latency", 64'(cyc - e.icyc), 64'(e.lat));
        end
      end
      if (MEM_WE) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_we", 64'd1, 64'd0);
        end else begin
          wexp_t w;
          w = wr_q.pop_front();
          chk("mem_addr", MEM_ADDR, w.a);
          chk("mem_wdata", MEM_WDATA, w.d);
        end
      end
      if (chk_idle) begin
        chk("idle_busy", {63'b0, BUSY}, 64'd0);
        chk("idle_ready", {63'b0, READY}, 64'd0);
        chk("idle_mis", {63'b0, MISALIGN}, 64'd0);
        chk("idle_we", {63'b0, MEM_WE}, 64'd0);
        chk("idle_addr", MEM_ADDR, 64'd0);
        chk("idle_wdata", MEM_WDATA, 64'd0);
        chk("idle_rdata", RDATA, 64'd0);
      end
      if (fin_chk) begin
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("ready_count", 64'(done_cnt), 64'(nissued));
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a,
                       input logic [63:0] wd,
                       input logic [63:0] er, input logic em,
                       input int el, input logic hw,
                       input logic [63:0] wa,
                       input logic [63:0] wdv,
                       input logic bpulse);
    int n;
    int target;
    exp_t e;
    wexp_t w;
    n = 0;
    @(negedge CLK);
    while (BUSY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    e.rd = er; e.mis = em; e.lat = el; e.icyc = cyc;
    exp_q.push_back(e);
    if (hw) begin
      w.a = wa; w.d = wdv;
      wr_q.push_back(w);
    end
    nissued++;
    target = done_cnt + 1;
    REQ = 1'b1; WR = wr; SIZE = sz; UNS = uns;
    ADDR = a; WDATA = wd;
    @(negedge CLK);
    REQ = 1'b0;
    if (bpulse) begin
      REQ = 1'b1; WR = ~wr; SIZE = 2'b11;
      ADDR = 64'h30; WDATA = 64'hDEAD_BEEF;
      @(negedge CLK);
      REQ = 1'b0;
    end
    n = 0;
    while (done_cnt < target && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      $display("FAIL ready_timeout: got none want READY");
      $fatal(1, "timeout");
    end
  endtask

  task automatic idle_check_next;
    @(posedge CLK);
    #1 chk_idle = 1'b1;
    @(posedge CLK);
    #1 chk_idle = 1'b0;
  endtask

  logic [63:0] mis_rd;

  initial begin
    RESET = 1'b1; REQ = 1'b0; WR = 1'b0; SIZE = 2'b00;
    UNS = 1'b0; ADDR = '0; WDATA = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0; load_mem = 1'b0; chk_idle = 1'b1;
    @(posedge CLK);
    #1 chk_idle = 1'b0;

    issue(0, 2'b00, 0, 64'h17, 0, 64'hFFFF_FFFF_FFFF_FF88,
          0, 3, 0, 0, 0, 0);
    issue(0, 2'b10, 1, 64'h14, 0, 64'h0000_0000_8877_6655,
          0, 3, 0, 0, 0, 1);
    issue(0, 2'b01, 1, 64'h12, 0, 64'h0000_0000_0000_4433,
          0, 3, 0, 0, 0, 0);
    issue(0, 2'b01, 0, 64'h16, 0, 64'hFFFF_FFFF_FFFF_8877,
          0, 3, 0, 0, 0, 0);
    issue(1, 2'b01, 0, 64'h12, 64'hBEEF,
          64'hFFFF_FFFF_FFFF_8877, 0, 4,
          1, 64'h10, 64'h8877_6655_BEEF_2211, 1);
    issue(0, 2'b11, 0, 64'h10, 0, 64'h8877_6655_BEEF_2211,
          0, 3, 0, 0, 0, 0);
    issue(1, 2'b11, 0, 64'h20, 64'h0123_4567_89AB_CDEF,
          64'h8877_6655_BEEF_2211, 0, 2,
          1, 64'h20, 64'h0123_4567_89AB_CDEF, 1);
    issue(1, 2'b00, 0, 64'h27, 64'h55AA,
          64'h8877_6655_BEEF_2211, 0, 4,
          1, 64'h20, 64'hAA23_4567_89AB_CDEF, 0);
    issue(1, 2'b10, 0, 64'h24, 64'hFFFF_FFFF_1122_3344,
          64'h8877_6655_BEEF_2211, 0, 4,
          1, 64'h20, 64'h1122_3344_89AB_CDEF, 0);
    issue(0, 2'b11, 0, 64'h20, 0, 64'h1122_3344_89AB_CDEF,
          0, 3, 0, 0, 0, 0);
    issue(0, 2'b00, 0, 64'h08, 0, 64'hFFFF_FFFF_FFFF_FFF0,
          0, 3, 0, 0, 0, 0);
    issue(0, 2'b00, 1, 64'h08, 0, 64'h0000_0000_0000_00F0,
          0, 3, 0, 0, 0, 0);
    mis_rd = 64'h0000_0000_0000_00F0;
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 64'h16, 0, mis_rd, 1, 1, 0, 0, 0, 0);
    issue(0, 2'b11, 0, 64'h13, 0, mis_rd, 1, 1, 0, 0, 0, 0);
    issue(1, 2'b01, 0, 64'h21, 64'h1234, mis_rd, 1, 1,
          0, 0, 0, 0);
`else
    issue(0, 2'b10, 0, 64'h16, 0, 64'hFFFF_FFFF_8877_6655,
          0, 3, 0, 0, 0, 0);
    issue(0, 2'b11, 0, 64'h13, 0, 64'h8877_6655_BEEF_2211,
          0, 3, 0, 0, 0, 0);
    issue(1, 2'b01, 0, 64'h21, 64'h1234,
          64'h8877_6655_BEEF_2211, 0, 4,
          1, 64'h20, 64'h1122_3344_89AB_1234, 0);
`endif

    // abort a sub-double store while in RMW_RD
    @(negedge CLK);
    REQ = 1'b1; WR = 1'b1; SIZE = 2'b01;
    ADDR = 64'h12; WDATA = 64'h1234;
    @(negedge CLK);
    WR = 1'b0; SIZE = 2'b11; ADDR = 64'h20;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0; REQ = 1'b0; chk_idle = 1'b1;
    @(posedge CLK);
    #1 chk_idle = 1'b0;
    repeat (4) @(negedge CLK);
    idle_check_next();

    issue(0, 2'b11, 0, 64'h10, 0, 64'h8877_6655_BEEF_2211,
          0, 3, 0, 0, 0, 0);

    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1 fin_chk = 1'b1;
    @(posedge CLK);
    #1 fin_chk = 1'b0;
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, errs);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, memory read latency in cycles (legal 1..15).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 REQ  input  1  access request from control unit; sampled only in IDLE.
REQ-005 WR  input  1  0 = load, 1 = store (same encoding as control-unit DMEM_RW).
REQ-006 SIZE  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-007 UNS  input  1  1 = zero-extend load, 0 = sign-extend load.
REQ-008 ADDR  input  64  byte address.
REQ-009 WDATA  input  64  store data, right-aligned.
REQ-010 RDATA  output  64  extended load result, registered, held until next load completes.
REQ-011 READY  output  1  one-cycle completion pulse.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 MISALIGN  output  1  one-cycle error pulse, coincident with READY.
REQ-014 MEM_ADDR  output  64  doubleword-aligned address {addr_q[63:3],3'b000}; 0 in IDLE.
REQ-015 MEM_WE  output  1  memory write strobe.
REQ-016 MEM_WDATA  output  64  full doubleword write data.
REQ-017 MEM_RDATA  input  64  memory read data, valid WAIT_CYCLES cycles after MEM_ADDR is stable.

Function
REQ-018 States SHALL be IDLE, RD, WR_FULL, RMW_RD, RMW_WR, DONE, ERR; all outputs Moore (state and latched request only).
REQ-019 IDLE + REQ=1 SHALL latch ADDR, WR, SIZE, UNS, WDATA into addr_q/wr_q/size_q/uns_q/wdata_q.
REQ-020 IDLE transitions: misaligned -> ERR; load -> RD; store SIZE=11 -> WR_FULL; store SIZE<11 -> RMW_RD.
REQ-021 Misaligned: half with ADDR[0]!=0, word with ADDR[1:0]!=0, double with ADDR[2:0]!=0.
REQ-022 RD and RMW_RD SHALL each last exactly WAIT_CYCLES cycles, counted by a 4-bit counter cleared on entry.
REQ-023 Last RD cycle: RDATA <= extend(lane of MEM_RDATA at byte offset addr_q[2:0], little-endian, width size_q); next state DONE.
REQ-024 Extension: UNS=1 zero-fill bits above size; UNS=0 replicate lane MSB; SIZE=11 passes 64 bits unchanged.
REQ-025 WR_FULL: MEM_WE=1, MEM_WDATA=wdata_q, one cycle, then DONE.
REQ-026 Last RMW_RD cycle SHALL capture MEM_RDATA into merge register; next RMW_RD -> RMW_WR.
REQ-027 RMW_WR: MEM_WE=1, MEM_WDATA = captured doubleword with selected lane replaced by wdata_q low bits; other bytes unchanged; one cycle, then DONE.
REQ-028 DONE: READY=1 one cycle, then IDLE; REQ sampled again in the IDLE cycle after DONE.
REQ-029 ERR: READY=1 and MISALIGN=1 one cycle, then IDLE; no MEM_WE, RDATA unchanged.
REQ-030 Latency REQ-cycle to READY: load WAIT_CYCLES+1; store double 2; store sub-double WAIT_CYCLES+2; misaligned 1.
REQ-031 REQ while BUSY=1 SHALL be ignored, no queuing.
REQ-032 MEM_WE SHALL never be high outside WR_FULL/RMW_WR; MEM_WDATA = 0 outside those states.
REQ-033 Stores SHALL NOT modify RDATA.

Reset
REQ-034 RESET=1 at a clock edge SHALL force IDLE, counter 0, RDATA=0, merge register 0, latched request 0.
REQ-035 Outputs after reset: READY=0, BUSY=0, MISALIGN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
REQ-036 Reset mid-operation SHALL abort without READY or MEM_WE in the cycle following reset; reset has priority over REQ.

Configuration
REQ-037 Macro DMEM_CTRL_MISALIGN_TRAP_EN defined: misalignment detected per REQ-021 and routed to ERR.
REQ-038 Macro undefined: no ERR state, MISALIGN tied 0, addr_q low bits truncated to natural alignment of SIZE and access proceeds normally.

Verification
REQ-039 WAIT_CYCLES=2, mem[0x10]=0x8877665544332211, load SIZE=00 ADDR=0x17 UNS=0 -> READY 3 cycles after REQ, RDATA=0xFFFFFFFFFFFFFF88.
REQ-040 Same memory, load SIZE=10 ADDR=0x14 UNS=1 -> RDATA=0x0000000088776655.
REQ-041 Store SIZE=01 ADDR=0x12 WDATA=0xBEEF on that doubleword -> one MEM_WE pulse, MEM_WDATA=0x88776655BEEF2211, READY 4 cycles after REQ.
REQ-042 Store SIZE=11 ADDR=0x20 WDATA=0x0123456789ABCDEF -> MEM_WE in cycle 1, MEM_ADDR=0x20, READY in cycle 2.
REQ-043 Macro defined, load SIZE=10 ADDR=0x16 -> READY=MISALIGN=1 in cycle 1, no MEM_WE, RDATA unchanged; undefined -> reads doubleword 0x10 at offset 4.
REQ-044 RESET during RMW_RD, then REQ pulses while BUSY -> no MEM_WE, no READY, BUSY=0 after reset, BUSY-time REQs ignored.
